// File: rtl/fpnew_result_buffer.sv
// Result decoupling FIFO between the FPU output stage and core writeback.
// Latency: one cycle from push to head valid; one result per cycle sustained.
// Backpressure: in_ready_o depends only on the occupancy register, so downstream stalls never reach the pipeline combinationally.
module fpnew_result_buffer #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter type TagType = logic,
  parameter type AuxType = logic
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] result_i,
  input  logic [4:0]       status_i,
  input  logic             extension_bit_i,
  input  TagType           tag_i,
  input  AuxType           aux_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [Width-1:0] result_o,
  output logic [4:0]       status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output AuxType           aux_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0]       fflags_o,
  input  logic             fflags_clr_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic             busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [Width-1:0] result;
    logic [4:0]       status;
    logic             ext;
    TagType           tag;
    AuxType           aux;
  } entry_t;

  entry_t          mem [Depth];
  logic [PtrW-1:0] wp;
  logic [PtrW-1:0] rp;
  logic [CntW-1:0] cnt;
  logic            push;
  logic            pop;
  entry_t          head;

  // Full/empty come from the count alone; pointer equality is ambiguous when full.
  assign in_ready_o  = (cnt != CntW'(Depth));
  assign out_valid_o = (cnt != '0);
  assign busy_o      = out_valid_o;
  assign usage_o     = cnt;

  // A flush cancels both handshakes in its cycle.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign head            = mem[rp];
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext;
  assign tag_o           = head.tag;
  assign aux_o           = head.aux;

  // Entry storage: write at wp on push; fully cleared by reset so outputs read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wp] <= '{result: result_i, status: status_i, ext: extension_bit_i,
                   tag: tag_i, aux: aux_i};
    end
  end

  // Pointers and occupancy; pointers wrap explicitly so Depth need not be a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= (wp == PtrW'(Depth - 1)) ? '0 : wp + PtrW'(1);
      if (pop)  rp <= (rp == PtrW'(Depth - 1)) ? '0 : rp + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky exception flags; a pop in the clearing cycle still leaves its flags set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_o <= '0;
    end else begin
      fflags_o <= (fflags_clr_i ? 5'b0 : fflags_o) | (pop ? head.status : 5'b0);
    end
  end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed bench for fpnew_result_buffer with hand-computed expectations.
module tb_fpnew_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_i;
  logic [4:0]  status_i;
  logic        extension_bit_i;
  logic        tag_i;
  logic        aux_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [31:0] result_o;
  logic [4:0]  status_o;
  logic        extension_bit_o;
  logic        tag_o;
  logic        aux_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic [2:0]  usage_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpnew_result_buffer #(.Width(32), .Depth(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .result_i(result_i), .status_i(status_i), .extension_bit_i(extension_bit_i),
    .tag_i(tag_i), .aux_i(aux_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .flush_i(flush_i),
    .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o),
    .tag_o(tag_o), .aux_o(aux_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .usage_o(usage_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_in_ready"}, 64'(in_ready_o), 64'd1);
    check({pfx, "_out_valid"}, 64'(out_valid_o), 64'd0);
    check({pfx, "_busy"}, 64'(busy_o), 64'd0);
    check({pfx, "_usage"}, 64'(usage_o), 64'd0);
    check({pfx, "_fflags"}, 64'(fflags_o), 64'd0);
    check({pfx, "_result"}, 64'(result_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; result_i = '0; status_i = '0; extension_bit_i = 1'b0;
    tag_i = 1'b0; aux_i = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0;
    out_ready_i = 1'b0; fflags_clr_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("rst");

    // Single item: pushed in one cycle, visible the next, flags the one after.
    result_i = 32'h3F80_0000; status_i = 5'b00001; tag_i = 1'b1;
    extension_bit_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("single_valid", 64'(out_valid_o), 64'd1);
    check("single_result", 64'(result_o), 64'h3F80_0000);
    check("single_status", 64'(status_o), 64'd1);
    check("single_tag", 64'(tag_o), 64'd1);
    check("single_ext", 64'(extension_bit_o), 64'd1);
    tick();
    check("single_fflags", 64'(fflags_o), 64'b00001);
    check("single_busy", 64'(busy_o), 64'd0);

    // Fill to Depth with downstream stalled.
    out_ready_i = 1'b0; status_i = 5'b0; tag_i = 1'b0; extension_bit_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      result_i = 32'(i); in_valid_i = 1'b1;
      tick();
    end
    check("fill_in_ready", 64'(in_ready_o), 64'd0);
    check("fill_usage", 64'(usage_o), 64'd4);
    result_i = 32'd5;
    tick();
    in_valid_i = 1'b0;
    check("fill_reject5", 64'(usage_o), 64'd4);
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), 64'(result_o), 64'(i));
      tick();
      if (i == 1) check("drain_ready_back", 64'(in_ready_o), 64'd1);
    end
    check("drain_empty", 64'(out_valid_o), 64'd0);

    // Streaming through pointer wrap: push and pop every cycle.
    for (int i = 0; i < 10; i++) begin
      result_i = 32'h100 + 32'(i); in_valid_i = 1'b1;
      if (i > 0) check($sformatf("stream_%0d", i - 1), 64'(result_o), 64'(32'h100 + 32'(i - 1)));
      tick();
      check($sformatf("stream_usage_%0d", i), 64'(usage_o), 64'd1);
    end
    in_valid_i = 1'b0;
    check("stream_last", 64'(result_o), 64'h109);
    tick();
    check("stream_empty", 64'(usage_o), 64'd0);
    check("stream_fflags", 64'(fflags_o), 64'b00001);

    // Flush with 3 entries held, handshakes asserted in the flush cycle.
    out_ready_i = 1'b0; status_i = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      result_i = 32'hA1 + 32'(i); in_valid_i = 1'b1;
      tick();
    end
    check("flush_pre_usage", 64'(usage_o), 64'd3);
    flush_i = 1'b1; result_i = 32'hEE; out_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_usage", 64'(usage_o), 64'd0);
    check("flush_valid", 64'(out_valid_o), 64'd0);
    check("flush_fflags", 64'(fflags_o), 64'b00001);
    tick();
    check("flush_not_stored", 64'(usage_o), 64'd0);

    // Sticky clear racing a pop.
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    check("clr_zero", 64'(fflags_o), 64'd0);
    status_i = 5'b10000; result_i = 32'h11; in_valid_i = 1'b1; out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    check("race_pre", 64'(fflags_o), 64'b10000);
    status_i = 5'b00100; result_i = 32'h22; in_valid_i = 1'b1; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b1; fflags_clr_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("race_survive", 64'(fflags_o), 64'b00100);
    tick();
    fflags_clr_i = 1'b0;
    check("race_clear", 64'(fflags_o), 64'd0);

    // Reset with 2 entries held and flags set.
    status_i = 5'b00010; out_ready_i = 1'b1; in_valid_i = 1'b1;
    result_i = 32'hB0;
    tick();
    result_i = 32'hB1;
    tick();
    result_i = 32'hB2; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    check("prerst_usage", 64'(usage_o), 64'd2);
    check("prerst_fflags", 64'(fflags_o), 64'b00010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postrst_novalid_%0d", i), 64'(out_valid_o), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpnew_result_buffer.md
# fpnew_result_buffer

Decoupling FIFO that sits directly downstream of the FPU output pipeline stage and upstream of the core writeback port. It accepts one result per cycle over a valid/ready handshake and stores up to `Depth` entries. Its `in_ready_o` is registered, so a downstream stall never propagates combinationally into the pipeline. It also accumulates sticky IEEE exception flags for retired results, for the core's fflags CSR.

## Interface
- `Width`, 32: result width in bits.
- `Depth`, 4: number of entries; must be ≥ 2. Need not be a power of two.
- `TagType`, logic: operation tag type, passed through unchanged.
- `AuxType`, logic: auxiliary sideband type, passed through unchanged.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `result_i`  in  Width  incoming result.
- `status_i`  in  5 (`fpnew_pkg::status_t` {NV,DZ,OF,UF,NX})  incoming exception flags.
- `extension_bit_i`  in  1  NaN-boxing/extension bit.
- `tag_i`  in  TagType  incoming tag.
- `aux_i`  in  AuxType  incoming aux data.
- `in_valid_i`  in  1  upstream item valid.
- `in_ready_o`  out  1  buffer can accept an item; registered.
- `flush_i`  in  1  synchronous discard of all buffered entries.
- `result_o`, `status_o`, `extension_bit_o`, `tag_o`, `aux_o`  out  as inputs  head entry.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  downstream accepts the head entry.
- `fflags_o`  out  5  sticky OR of `status` over all popped entries.
- `fflags_clr_i`  in  1  clear the sticky flags.
- `usage_o`  out  $clog2(Depth+1)  current occupancy.
- `busy_o`  out  1  at least one entry is buffered.

## Operation
- **Storage:** circular array of `Depth` entries {result, status, ext, tag, aux}, with a write pointer `wp`, a read pointer `rp` and a count `cnt`.
- **Wrap-around:** pointers wrap from `Depth-1` to 0. `cnt` is the single source of full/empty; pointer equality is never used.
- **Push:** `push = in_valid_i & in_ready_o & ~flush_i`. Writes entry at `wp`, then `wp++`.
- **Pop:** `pop = out_valid_o & out_ready_i & ~flush_i`. Then `rp++`.
- **Count:** `cnt` next = `cnt + push - pop`.
  - Push and pop in the same cycle are legal whenever `0 < cnt < Depth`; `cnt` is unchanged.
- **Full:** `in_ready_o = (cnt != Depth)`, a function of registered state only.
  - When full, a same-cycle pop does not allow a push; the slot frees one cycle later.
- **Empty:** `out_valid_o = (cnt != 0)`.
  - Head data outputs are driven from the entry at `rp`.
  - Data outputs are don't-care while `out_valid_o = 0`.
- **Flush:** `flush_i = 1` sets `wp = rp = cnt = 0` and suppresses any push or pop in that cycle.
  - Flush does not alter `fflags_o`.
- **Sticky flags:** next `fflags_o` = (`fflags_clr_i` ? 0 : `fflags_o`) | (`pop` ? `status_o` : 0).
  - When clear and pop happen in the same cycle, the popped flags survive.
- **Status outputs:**
  - `usage_o = cnt`.
  - `busy_o = (cnt != 0)`.
- **Reset:** `rst_i` overrides flush and all handshakes. It zeroes `wp`, `rp`, `cnt`, `fflags_o` and all storage.
  - A reset asserted mid-stream drops all entries with no pop.

## Timing
- **Reset values:** `in_ready_o = 1`, `out_valid_o = 0`, `busy_o = 0`, `usage_o = 0`, `fflags_o = 0`.
  - Data outputs are 0, since storage is reset.
- **Latency:** an item pushed in cycle N is presented with `out_valid_o = 1` in cycle N+1. There is no combinational input-to-output path.
- **Throughput:** 1 item/cycle sustained when `out_ready_i = 1`.
- **Handshake stability:** once `out_valid_o = 1`, the head data is stable until the pop. The upstream stage must keep its item stable while `in_ready_o = 0`.
- **Flag timing:** `fflags_o` reflects a popped entry's status in the cycle after the pop.
- **Order:** results leave strictly in FIFO order, with no reordering.

## Test plan
- **Single item, latency:** reset, then push `result=0x3F800000`, `status=5'b00001`, `tag=1` in cycle 1 with `out_ready_i = 1`.
  - Expect `out_valid_o = 1` with the same data in cycle 2.
  - Expect pop in cycle 2, then `fflags_o = 5'b00001` in cycle 3 and `busy_o = 0`.
- **Fill and stall (Depth = 4):** hold `out_ready_i = 0` and push 0x1, 0x2, 0x3, 0x4 back-to-back.
  - Expect `in_ready_o = 0` from the cycle after the 4th push, with `usage_o = 4`.
  - A 5th valid is not accepted.
  - Raise `out_ready_i`: expect outputs 0x1..0x4 in order, and `in_ready_o = 1` the cycle after the first pop.
- **Streaming with wrap-around:** push 10 items with simultaneous push and pop every cycle.
  - Expect `usage_o` constant at 1, and outputs in order through pointer wrap.
  - Expect no lost or duplicated items.
- **Flush mid-stream:** with 3 entries held, assert `flush_i` together with `in_valid_i` and `out_ready_i`.
  - Next cycle expect `usage_o = 0`, `out_valid_o = 0`, no pop and `fflags_o` unchanged.
  - The flushed-cycle input is not stored.
- **Sticky clear race:** with `fflags_o = 5'b10000`, pop an entry with `status = 5'b00100` while `fflags_clr_i = 1`.
  - Expect `fflags_o = 5'b00100`.
  - Clear alone in the following cycle gives 0.
- **Reset mid-operation:** with 2 entries held and `fflags_o ≠ 0`, assert `rst_i` for 1 cycle.
  - Expect all reset values next cycle.
  - Expect no item to appear afterwards.
